// File: rtl/seg_pkg.sv
// Shared types and constants for the scrolling 7-segment display.
// Glyphs are {g,f,e,d,c,b,a}, active-high.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic [4:0] CH_BLANK = 5'd16;
    localparam logic [4:0] CH_DASH  = 5'd17;

    localparam logic [6:0] GLYPH_0     = 7'b0111111;
    localparam logic [6:0] GLYPH_1     = 7'b0000110;
    localparam logic [6:0] GLYPH_2     = 7'b1011011;
    localparam logic [6:0] GLYPH_3     = 7'b1001111;
    localparam logic [6:0] GLYPH_4     = 7'b1100110;
    localparam logic [6:0] GLYPH_5     = 7'b1101101;
    localparam logic [6:0] GLYPH_6     = 7'b1111101;
    localparam logic [6:0] GLYPH_7     = 7'b0000111;
    localparam logic [6:0] GLYPH_8     = 7'b1111111;
    localparam logic [6:0] GLYPH_9     = 7'b1101111;
    localparam logic [6:0] GLYPH_A     = 7'b1110111;
    localparam logic [6:0] GLYPH_B     = 7'b1111100;
    localparam logic [6:0] GLYPH_C     = 7'b0111001;
    localparam logic [6:0] GLYPH_D     = 7'b1011110;
    localparam logic [6:0] GLYPH_E     = 7'b1111001;
    localparam logic [6:0] GLYPH_F     = 7'b1110001;
    localparam logic [6:0] GLYPH_DASH  = 7'b1000000;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_decoder.sv
// Character code to 7-segment pattern, purely combinational.
// Codes other than the hex digits and dash render blank.
module seg7_decoder (
    input  logic [4:0] code_i,
    output logic [6:0] seg_o
);
    import seg_pkg::*;

    always_comb begin
        seg_o = GLYPH_BLANK;
        case (code_i)
            5'd0:    seg_o = GLYPH_0;
            5'd1:    seg_o = GLYPH_1;
            5'd2:    seg_o = GLYPH_2;
            5'd3:    seg_o = GLYPH_3;
            5'd4:    seg_o = GLYPH_4;
            5'd5:    seg_o = GLYPH_5;
            5'd6:    seg_o = GLYPH_6;
            5'd7:    seg_o = GLYPH_7;
            5'd8:    seg_o = GLYPH_8;
            5'd9:    seg_o = GLYPH_9;
            5'd10:   seg_o = GLYPH_A;
            5'd11:   seg_o = GLYPH_B;
            5'd12:   seg_o = GLYPH_C;
            5'd13:   seg_o = GLYPH_D;
            5'd14:   seg_o = GLYPH_E;
            5'd15:   seg_o = GLYPH_F;
            CH_DASH: seg_o = GLYPH_DASH;
            default: seg_o = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scroll_display.sv
// Multiplexed multi-digit 7-segment driver with a scrolling message buffer.
// Outputs are registered from the current scan index, offset and buffer.
module seg_scroll_display #(
    parameter int NUM_DIGITS  = 8,
    parameter int MSG_LEN     = 16,
    parameter int REFRESH_DIV = 1000,
    parameter int SCROLL_DIV  = 5000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       left,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [4:0]                 wr_data,
    output logic [NUM_DIGITS-1:0]      digit,
    output logic [6:0]                 seg_data,
    output logic                       running
);
    import seg_pkg::*;

    localparam int AW = $clog2(MSG_LEN);
    localparam int SW = $clog2(NUM_DIGITS);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int CW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    state_e                state_q;
    logic                  start_q;
    logic                  running_q;
    logic [AW-1:0]         offset_q, offset_d;
    logic [CW-1:0]         scroll_cnt_q, scroll_cnt_d;
    logic [RW-1:0]         ref_cnt_q, ref_cnt_d;
    logic [SW-1:0]         scan_q, scan_d;
    logic [4:0]            buf_q [MSG_LEN];
    logic [NUM_DIGITS-1:0] digit_q;
    logic [6:0]            seg_q;

    logic          start_edge;
    logic          scroll_tc;
    logic          ref_tc;
    logic          wr_ok;
    logic [AW:0]   win_sum;
    logic [AW-1:0] sel_idx;
    logic [4:0]    sel_code;
    logic [6:0]    sel_glyph;

    assign start_edge = start & ~start_q;
    assign scroll_tc  = (scroll_cnt_q == CW'(SCROLL_DIV - 1));
    assign ref_tc     = (ref_cnt_q == RW'(REFRESH_DIV - 1));
    assign wr_ok      = wr_en & ({1'b0, wr_addr} < (AW+1)'(MSG_LEN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
        end else if (start_edge) begin
            case (state_q)
                ST_RUN: begin
                    state_q   <= ST_PAUSE;
                    running_q <= 1'b0;
                end
                default: begin
                    state_q   <= ST_RUN;
                    running_q <= 1'b1;
                end
            endcase
        end
    end

    // Pause freezes the scroll position; idle pins it at the start.
    always_comb begin
        scroll_cnt_d = scroll_cnt_q;
        offset_d     = offset_q;
        case (state_q)
            ST_RUN: begin
                if (scroll_tc) begin
                    scroll_cnt_d = '0;
                    if (left)
                        offset_d = (offset_q == AW'(MSG_LEN - 1)) ?
                                   '0 : offset_q + 1'b1;
                    else
                        offset_d = (offset_q == '0) ?
                                   AW'(MSG_LEN - 1) : offset_q - 1'b1;
                end else begin
                    scroll_cnt_d = scroll_cnt_q + 1'b1;
                end
            end
            ST_PAUSE: begin
                scroll_cnt_d = scroll_cnt_q;
                offset_d     = offset_q;
            end
            default: begin
                scroll_cnt_d = '0;
                offset_d     = '0;
            end
        endcase
    end

    always_comb begin
        ref_cnt_d = ref_tc ? '0 : ref_cnt_q + 1'b1;
        scan_d    = scan_q;
        if (ref_tc)
            scan_d = (scan_q == SW'(NUM_DIGITS - 1)) ? '0 : scan_q + 1'b1;
    end

    // Sum is below 2*MSG_LEN, so one conditional subtract is the modulo.
    always_comb begin
        win_sum = {1'b0, offset_q} + (AW+1)'(NUM_DIGITS - 1)
                - (AW+1)'(scan_q);
        if (win_sum >= (AW+1)'(MSG_LEN))
            sel_idx = AW'(win_sum - (AW+1)'(MSG_LEN));
        else
            sel_idx = win_sum[AW-1:0];
    end

    assign sel_code = buf_q[sel_idx];

    seg7_decoder u_dec (
        .code_i (sel_code),
        .seg_o  (sel_glyph)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q      <= 1'b0;
            offset_q     <= '0;
            scroll_cnt_q <= '0;
            ref_cnt_q    <= '0;
            scan_q       <= '0;
        end else begin
            start_q      <= start;
            offset_q     <= offset_d;
            scroll_cnt_q <= scroll_cnt_d;
            ref_cnt_q    <= ref_cnt_d;
            scan_q       <= scan_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MSG_LEN; i++)
                buf_q[i] <= CH_BLANK;
        end else if (wr_ok) begin
            buf_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= '1;
            seg_q   <= GLYPH_BLANK;
        end else begin
            digit_q <= ~(NUM_DIGITS'(1) << scan_q);
            seg_q   <= sel_glyph;
        end
    end

    assign digit    = digit_q;
    assign seg_data = seg_q;
    assign running  = running_q;

endmodule
